serial_word_deser: RTL and testbench

- Deserializer that assembles framed serial bits into WIDTH-bit parallel words.
- Presents each word on a valid/ready output; sits directly upstream of the 8-bit holding register and drives its input word.
- Output word is held stable until the consumer accepts it. Words that complete while the output is still occupied are dropped and flagged.

---
 rtl/serial_word_deser.sv | 73 +++++++
 tb/tb_serial_word_deser.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/serial_word_deser.sv
// serial_word_deser: framed serial-to-parallel deserializer with a valid/ready output slot.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit per frame and report parity_err.
module serial_word_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin_data,
  input  logic             sin_valid,
  input  logic             sin_start,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             parity_err
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`ifdef PARITY_CHECK_EN
  localparam state_t DONE_ST = PARITY;
`else
  localparam state_t DONE_ST = IDLE;
`endif
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sr, fresh, shifted, done_word;
  logic last, take, done, perr;
  always_comb begin
    fresh   = MSB_FIRST ? {{(WIDTH-1){1'b0}}, sin_data} : {sin_data, {(WIDTH-1){1'b0}}};
    shifted = MSB_FIRST ? {sr[WIDTH-2:0], sin_data} : {sin_data, sr[WIDTH-1:1]};
    last    = state == SHIFT && cnt == CW'(WIDTH - 1);
    take    = sin_valid && !sin_start;
`ifdef PARITY_CHECK_EN
    done      = state == PARITY && take;
    done_word = sr;
    perr      = ^sr ^ sin_data;
`else
    done      = last && take;
    done_word = shifted;
    perr      = 1'b0;
`endif
  end
  // a start bit resyncs from any state; the output slot frees on accept or reloads in the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      out_word   <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (done && (!out_valid || out_ready)) begin
        out_valid  <= 1'b1;
        out_word   <= done_word;
        parity_err <= perr;
      end else if (done) overrun <= 1'b1;
      if (sin_valid && sin_start) begin
        state <= SHIFT;
        cnt   <= CW'(1);
        sr    <= fresh;
      end else if (sin_valid && state == SHIFT) begin
        sr    <= shifted;
        cnt   <= last ? '0 : cnt + CW'(1);
        state <= last ? DONE_ST : SHIFT;
      end else if (sin_valid && state == PARITY) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_word_deser.sv
// tb_serial_word_deser: directed frames into MSB-first and LSB-first instances, checked by a queue-based monitor.
module tb_serial_word_deser;
  logic clk = 0, reset = 0, sin_data = 0, sin_valid = 0, sin_start = 0, out_ready = 0;
  logic [7:0] ow1, ow0;
  logic ov1, ov0, orun1, orun0, pe1, pe0;
  int n_cmp = 0, n_err = 0, cyc = 0, exp_ov = 0, seen_ov = 0;
  typedef struct {logic [7:0] w; logic p; int c;} exp_t;
  exp_t q[$];

  serial_word_deser #(.WIDTH(8), .MSB_FIRST(1)) dut1 (
    .clk(clk), .reset(reset), .sin_data(sin_data), .sin_valid(sin_valid), .sin_start(sin_start),
    .out_word(ow1), .out_valid(ov1), .out_ready(out_ready), .overrun(orun1), .parity_err(pe1));
  serial_word_deser #(.WIDTH(8), .MSB_FIRST(0)) dut0 (
    .clk(clk), .reset(reset), .sin_data(sin_data), .sin_valid(sin_valid), .sin_start(sin_start),
    .out_word(ow0), .out_valid(ov0), .out_ready(out_ready), .overrun(orun0), .parity_err(pe0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] rev(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic put_bit(input logic d, input logic s, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
    sin_data = d; sin_start = s; sin_valid = 1;
    @(posedge clk); #1;
    sin_valid = 0; sin_start = 0;
  endtask

  // bits go out w[7] first, so the MSB-first instance rebuilds w and the LSB-first one rev(w)
  task automatic send_frame(input logic [7:0] w, input bit ov, input bit rdy_last, input bit gap, input bit bad);
    exp_t e;
    logic p;
    p = 1'b0;
    for (int i = 7; i >= 0; i--) begin
`ifndef PARITY_CHECK_EN
      if (i == 0 && rdy_last) out_ready = 1;
`endif
      put_bit(w[i], i == 7, gap ? 1 + (i % 4) : 0);
    end
`ifdef PARITY_CHECK_EN
    if (rdy_last) out_ready = 1;
    put_bit(^w ^ bad, 1'b0, gap ? 2 : 0);
    p = bad;
`endif
    if (ov) exp_ov++;
    else begin
      e.w = w; e.p = p; e.c = cyc;
      q.push_back(e);
    end
    if (rdy_last) out_ready = 0;
  endtask

  logic pv = 0, pacc = 0, pov = 0;
  logic [7:0] held1, held0;
  always @(negedge clk) begin
    if (!reset) begin
      pv = 0; pacc = 0; pov = 0;
    end else begin
      check("valid_lockstep", ov0, ov1);
      if (ov1 && (!pv || pacc)) begin
        check("word_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          check("word_msb_first", ow1, e.w);
          check("word_lsb_first", ow0, rev(e.w));
          check("parity_err", {pe1, pe0}, {e.p, e.p});
          check("word_latency", cyc, e.c);
        end
        held1 = ow1; held0 = ow0;
      end else if (ov1) begin
        check("hold_msb_first", ow1, held1);
        check("hold_lsb_first", ow0, held0);
      end
      if (orun1 || orun0) begin
        check("overrun_lockstep", orun0, orun1);
        check("overrun_one_cycle", pov, 0);
        seen_ov++;
      end
      pov = orun1;
      pv = ov1;
      pacc = ov1 && out_ready;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_word", {ow1, ow0}, 16'h0);
    check("reset_flags", {ov1, ov0, orun1, orun0, pe1, pe0}, 6'b0);
    reset = 1;
    send_frame(8'hAF, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1 out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    send_frame(8'h80, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    send_frame(8'h02, 0, 0, 0, 0);
    send_frame(8'hFF, 1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 send_frame(8'hFF, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1 out_ready = 1;
    put_bit(1, 1, 0); put_bit(1, 0, 0); put_bit(0, 0, 0);
    send_frame(8'h55, 0, 0, 0, 0);
    send_frame(8'h55, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1 out_ready = 0;
    send_frame(8'hA5, 0, 0, 0, 0);
    put_bit(1, 1, 0); put_bit(0, 0, 0); put_bit(1, 0, 0); put_bit(1, 0, 0);
    #2 reset = 0;
    #1;
    check("async_reset_word", {ow1, ow0}, 16'h0);
    check("async_reset_valid", {ov1, ov0}, 2'b0);
    @(posedge clk); #1 reset = 1;
    send_frame(8'h3C, 0, 0, 0, 0);
    #1 out_ready = 1;
    send_frame(8'hFF, 0, 0, 0, 0);
    send_frame(8'h01, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    check("overrun_count", seen_ov, exp_ov);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
